// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the program counter, issues single-outstanding
// word reads to instruction memory, buffers returned words in a two-entry
// prefetch queue and drives the IF/ID register (instruction, PC, flush, hold).
// Control-transfer redirects empty the queue, and any fetch that is still
// in flight is marked stale so its data is dropped when it returns.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic        flush_out,
    output logic        ifid_hold_out
);

    // IDLE: nothing outstanding; FETCH: request outstanding, data wanted;
    // DISCARD: request outstanding but made stale by a redirect.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    // Address of the next (or currently outstanding) fetch.
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    // Redirect target parked while a stale request drains.
    logic [31:0] pc_pending_q;
    logic [31:0] pc_pending_d;

    // Queue occupancy and read pointer; the write slot is derived from them.
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic        head_q;
    logic        head_d;
    logic        tail_idx;

    // Prefetch queue storage: one {instruction, pc} pair per slot.
    logic [31:0] q_instr_q [QDEPTH];
    logic [31:0] q_pc_q    [QDEPTH];

    logic        push;
    logic        pop;
    logic        fetch_done;
    logic        queue_empty;
    logic [31:0] redirect_word;
    logic [31:0] pc_plus4;

    // Low address bits of a redirect target are ignored (word aligned fetch).
    assign redirect_word = redirect_pc & 32'hFFFF_FFFC;
    // Sequential successor; wraps naturally at the top of the address space.
    assign pc_plus4      = pc_q + 32'd4;

    assign queue_empty   = (count_q == 2'd0);
    // An ack only completes something when a request is actually outstanding.
    assign fetch_done    = imem_ack && ((state_q == ST_FETCH) || (state_q == ST_DISCARD));
    // Redirect takes priority over both the consume and the enqueue paths.
    assign pop           = !queue_empty && !stall_in && !redirect_valid;
    assign push          = (state_q == ST_FETCH) && imem_ack && !redirect_valid;
    // With at most two entries the free slot sits count positions past head.
    assign tail_idx      = head_q ^ count_q[0];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register: asynchronous active-low reset back to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a new fetch starts only while the queue has room.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect_valid || (count_q < 2'd2)) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    state_d = imem_ack ? ST_FETCH : ST_DISCARD;
                end else if (imem_ack) begin
                    state_d = (count_d < 2'd2) ? ST_FETCH : ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (imem_ack) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: a request is presented whenever one is outstanding.
    always_comb begin
        imem_req = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
    end

    // ------------------------------------------------------------------
    // Program counter and queue bookkeeping
    // ------------------------------------------------------------------

    // Next PC: redirect target when it can be taken now, else sequential
    // advance on an accepted word, else the parked target after a stale ack.
    always_comb begin
        pc_d         = pc_q;
        pc_pending_d = pc_pending_q;
        if (redirect_valid) begin
            if ((state_q == ST_IDLE) || fetch_done) begin
                pc_d = redirect_word;
            end else begin
                // Outstanding address must stay on the bus until its ack.
                pc_pending_d = redirect_word;
            end
        end else if (push) begin
            pc_d = pc_plus4;
        end else if ((state_q == ST_DISCARD) && imem_ack) begin
            pc_d = pc_pending_q;
        end
    end

    // Occupancy and head pointer: redirect empties the queue outright.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        if (redirect_valid) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
            if (pop) begin
                head_d = ~head_q;
            end
        end
    end

    // Control registers: PC, parked target, occupancy and head pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            pc_pending_q <= RESET_PC;
            count_q      <= 2'd0;
            head_q       <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pc_pending_q <= pc_pending_d;
            count_q      <= count_d;
            head_q       <= head_d;
        end
    end

    // Queue slots hold data only; validity is tracked by count_q, so the
    // storage itself needs no reset.
    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_slot
            localparam logic SLOT = 1'(gi);

            // Capture the returned word and its fetch address into the tail slot.
            always_ff @(posedge clk) begin
                if (push && (tail_idx == SLOT)) begin
                    q_instr_q[gi] <= imem_rdata;
                    q_pc_q[gi]    <= pc_q;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // IF/ID facing outputs
    // ------------------------------------------------------------------

    assign imem_addr       = pc_q & 32'hFFFF_FFFC;
    // Redirect forces a bubble even when the hazard unit asks for a hold.
    assign ifid_hold_out   = stall_in && !redirect_valid;
    assign flush_out       = redirect_valid || queue_empty;
    assign instruction_out = queue_empty ? 32'd0    : q_instr_q[head_q];
    assign pc_out          = queue_empty ? RESET_PC : q_pc_q[head_q];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit. A behavioural memory
// answers requests after a programmable number of wait cycles; a scoreboard
// holds the PCs IF/ID is expected to receive, in order, and a monitor pops
// and compares one entry every cycle IF/ID actually loads an instruction.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        flush_out;
    logic        ifid_hold_out;

    int vectors     = 0;
    int miscompares = 0;
    int n_consumed  = 0;
    int mem_lat     = 0;
    int wait_cnt    = 0;

    logic [31:0] sb[$];

    instruction_fetch_unit #(
        .RESET_PC(RESET_PC),
        .QDEPTH  (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instruction_out(instruction_out),
        .pc_out         (pc_out),
        .flush_out      (flush_out),
        .ifid_hold_out  (ifid_hold_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Memory model: acks a request once it has waited mem_lat cycles.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_ack) wait_cnt = 0;
            if (imem_req && (wait_cnt >= mem_lat)) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'd0;
                if (imem_req) wait_cnt = wait_cnt + 1;
                else          wait_cnt = 0;
            end
        end
    end

    // Monitor: every cycle IF/ID loads a real instruction, compare against
    // the scoreboard head.
    initial begin
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk);
            if (reset && !flush_out && !stall_in && !redirect_valid) begin
                n_consumed = n_consumed + 1;
                vectors = vectors + 1;
                if (sb.size() == 0) begin
                    miscompares = miscompares + 1;
                    $display("FAIL consume_unexpected: got pc %08h, want no instruction", pc_out);
                end else begin
                    exp_pc = sb.pop_front();
                    $display("consume pc=%08h instr=%08h", pc_out, instruction_out);
                    if (pc_out !== exp_pc) begin
                        miscompares = miscompares + 1;
                        $display("FAIL consume_pc: got %08h want %08h", pc_out, exp_pc);
                    end
                    vectors = vectors + 1;
                    if (instruction_out !== mem_word(exp_pc)) begin
                        miscompares = miscompares + 1;
                        $display("FAIL consume_instr: got %08h want %08h", instruction_out, mem_word(exp_pc));
                    end
                end
            end
        end
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
    endtask

    // Synchronous-looking reset sequence; returns at the start of cycle 1.
    task automatic do_reset(input int lat);
        next();
        reset          = 1'b0;
        stall_in       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        mem_lat        = lat;
        next();
        next();
        sb.delete();
        n_consumed = 0;
        next();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", imem_req); end
        vectors++; if (imem_addr !== RESET_PC) begin miscompares++; $display("FAIL reset_addr: got %08h want %08h", imem_addr, RESET_PC); end
        vectors++; if (instruction_out !== 32'd0) begin miscompares++; $display("FAIL reset_instr: got %08h want 0", instruction_out); end
        vectors++; if (pc_out !== RESET_PC) begin miscompares++; $display("FAIL reset_pc: got %08h want %08h", pc_out, RESET_PC); end
        vectors++; if (flush_out !== 1'b1) begin miscompares++; $display("FAIL reset_flush: got %b want 1", flush_out); end
        // Stall with an empty queue: hold and flush both asserted.
        vectors++; if (ifid_hold_out !== 1'b1) begin miscompares++; $display("FAIL empty_stall_hold: got %b want 1", ifid_hold_out); end
        next();
        stall_in = 1'b0;
        @(negedge clk);
        vectors++; if (ifid_hold_out !== 1'b0) begin miscompares++; $display("FAIL reset_hold: got %b want 0", ifid_hold_out); end
    endtask

    task automatic test_stream();
        do_reset(0);
        push_stream(RESET_PC, 32);
        @(negedge clk);
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL c1_req: got %b want 0", imem_req); end
        next(); @(negedge clk);
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL c2_req: got %b want 1", imem_req); end
        vectors++; if (imem_addr !== 32'h0040_0000) begin miscompares++; $display("FAIL c2_addr: got %08h want 00400000", imem_addr); end
        vectors++; if (flush_out !== 1'b1) begin miscompares++; $display("FAIL c2_flush: got %b want 1", flush_out); end
        next(); @(negedge clk);
        vectors++; if (imem_addr !== 32'h0040_0004) begin miscompares++; $display("FAIL c3_addr: got %08h want 00400004", imem_addr); end
        vectors++; if (flush_out !== 1'b0) begin miscompares++; $display("FAIL c3_flush: got %b want 0", flush_out); end
        next(); @(negedge clk);
        vectors++; if (imem_addr !== 32'h0040_0008) begin miscompares++; $display("FAIL c4_addr: got %08h want 00400008", imem_addr); end
        repeat (8) next();
        @(negedge clk);
        #1;
        vectors++; if (n_consumed !== 10) begin miscompares++; $display("FAIL stream_rate: got %0d instructions want 10", n_consumed); end
    endtask

    task automatic test_stall();
        bit done;
        do_reset(0);
        push_stream(RESET_PC, 32);
        repeat (3) next();
        next();
        stall_in = 1'b1;
        @(negedge clk);
        vectors++; if (ifid_hold_out !== 1'b1) begin miscompares++; $display("FAIL stall_hold: got %b want 1", ifid_hold_out); end
        vectors++; if (flush_out !== 1'b0) begin miscompares++; $display("FAIL stall_flush: got %b want 0", flush_out); end
        vectors++; if (pc_out !== 32'h0040_0008) begin miscompares++; $display("FAIL stall_pc: got %08h want 00400008", pc_out); end
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL stall_req_first: got %b want 1", imem_req); end
        for (int i = 0; i < 2; i++) begin
            next(); @(negedge clk);
            vectors++; if (ifid_hold_out !== 1'b1) begin miscompares++; $display("FAIL stall_hold_%0d: got %b want 1", i, ifid_hold_out); end
            vectors++; if (pc_out !== 32'h0040_0008) begin miscompares++; $display("FAIL stall_frozen_pc_%0d: got %08h want 00400008", i, pc_out); end
            vectors++; if (instruction_out !== mem_word(32'h0040_0008)) begin miscompares++; $display("FAIL stall_frozen_instr_%0d: got %08h want %08h", i, instruction_out, mem_word(32'h0040_0008)); end
            vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_full_req_%0d: got %b want 0", i, imem_req); end
        end
        next();
        stall_in = 1'b0;
        @(negedge clk);
        vectors++; if (ifid_hold_out !== 1'b0) begin miscompares++; $display("FAIL unstall_hold: got %b want 0", ifid_hold_out); end
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            next();
            if (n_consumed >= 8) done = 1'b1;
        end
        vectors++; if (!done) begin miscompares++; $display("FAIL stall_drain: got %0d instructions want 8", n_consumed); end
    endtask

    task automatic test_slow_memory();
        bit done;
        do_reset(3);
        push_stream(RESET_PC, 32);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            next(); @(negedge clk);
            vectors++; if (imem_addr !== 32'h0040_0000) begin miscompares++; $display("FAIL slow_addr_hold_%0d: got %08h want 00400000", i, imem_addr); end
            vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL slow_req_%0d: got %b want 1", i, imem_req); end
            vectors++; if (flush_out !== 1'b1) begin miscompares++; $display("FAIL slow_flush_%0d: got %b want 1", i, flush_out); end
        end
        next();
        next(); @(negedge clk);
        vectors++; if (imem_addr !== 32'h0040_0004) begin miscompares++; $display("FAIL slow_addr_next: got %08h want 00400004", imem_addr); end
        vectors++; if (flush_out !== 1'b0) begin miscompares++; $display("FAIL slow_valid: got %b want 0", flush_out); end
        next(); @(negedge clk);
        vectors++; if (flush_out !== 1'b1) begin miscompares++; $display("FAIL slow_empty_flush: got %b want 1", flush_out); end
        vectors++; if (imem_addr !== 32'h0040_0004) begin miscompares++; $display("FAIL slow_addr_stable: got %08h want 00400004", imem_addr); end
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            next();
            if (n_consumed >= 4) done = 1'b1;
        end
        vectors++; if (!done) begin miscompares++; $display("FAIL slow_drain: got %0d instructions want 4", n_consumed); end
    endtask

    task automatic test_redirect_discard();
        bit found;
        bit done;
        int base;
        do_reset(2);
        push_stream(RESET_PC, 32);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            next(); @(negedge clk);
            if (imem_req && (imem_addr == 32'h0040_0010)) found = 1'b1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL discard_setup: got no request want 00400010"); end
        next();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0100;
        sb.delete();
        push_stream(32'h0040_0100, 32);
        base = n_consumed;
        @(negedge clk);
        vectors++; if (flush_out !== 1'b1) begin miscompares++; $display("FAIL discard_flush: got %b want 1", flush_out); end
        vectors++; if (ifid_hold_out !== 1'b0) begin miscompares++; $display("FAIL discard_hold: got %b want 0", ifid_hold_out); end
        next();
        redirect_valid = 1'b0;
        @(negedge clk);
        vectors++; if (imem_addr !== 32'h0040_0010) begin miscompares++; $display("FAIL discard_addr_held: got %08h want 00400010", imem_addr); end
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL discard_req: got %b want 1", imem_req); end
        vectors++; if (flush_out !== 1'b1) begin miscompares++; $display("FAIL discard_queue_empty: got %b want 1", flush_out); end
        next(); @(negedge clk);
        vectors++; if (imem_addr !== 32'h0040_0100) begin miscompares++; $display("FAIL discard_target_addr: got %08h want 00400100", imem_addr); end
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            next();
            if (n_consumed - base >= 3) done = 1'b1;
        end
        vectors++; if (!done) begin miscompares++; $display("FAIL discard_resume: got %0d instructions want 3", n_consumed - base); end
    endtask

    task automatic test_redirect_ack_stall();
        bit done;
        int base;
        do_reset(0);
        push_stream(RESET_PC, 32);
        repeat (3) next();
        next();
        stall_in       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0103;
        sb.delete();
        push_stream(32'h0040_0100, 32);
        base = n_consumed;
        @(negedge clk);
        vectors++; if (ifid_hold_out !== 1'b0) begin miscompares++; $display("FAIL redir_ack_hold: got %b want 0", ifid_hold_out); end
        vectors++; if (flush_out !== 1'b1) begin miscompares++; $display("FAIL redir_ack_flush: got %b want 1", flush_out); end
        vectors++; if (imem_addr !== 32'h0040_000C) begin miscompares++; $display("FAIL redir_ack_addr: got %08h want 0040000c", imem_addr); end
        next();
        stall_in       = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        vectors++; if (imem_addr !== 32'h0040_0100) begin miscompares++; $display("FAIL redir_ack_target: got %08h want 00400100", imem_addr); end
        vectors++; if (flush_out !== 1'b1) begin miscompares++; $display("FAIL redir_ack_dropped: got %b want 1", flush_out); end
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            next();
            if (n_consumed - base >= 3) done = 1'b1;
        end
        vectors++; if (!done) begin miscompares++; $display("FAIL redir_ack_resume: got %0d instructions want 3", n_consumed - base); end
    endtask

    task automatic test_wrap_and_async_reset();
        bit done;
        bit found;
        int base;
        do_reset(0);
        push_stream(RESET_PC, 32);
        next();
        next();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        sb.delete();
        push_stream(32'hFFFF_FFFC, 32);
        base = n_consumed;
        next();
        redirect_valid = 1'b0;
        @(negedge clk);
        vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_top_addr: got %08h want fffffffc", imem_addr); end
        next(); @(negedge clk);
        vectors++; if (imem_addr !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap_zero_addr: got %08h want 00000000", imem_addr); end
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            next();
            if (n_consumed - base >= 3) done = 1'b1;
        end
        vectors++; if (!done) begin miscompares++; $display("FAIL wrap_stream: got %0d instructions want 3", n_consumed - base); end
        @(negedge clk);
        mem_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_req && !imem_ack) found = 1'b1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL async_setup: got no waiting request want one"); end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL async_req: got %b want 0", imem_req); end
        vectors++; if (imem_addr !== RESET_PC) begin miscompares++; $display("FAIL async_addr: got %08h want %08h", imem_addr, RESET_PC); end
        vectors++; if (pc_out !== RESET_PC) begin miscompares++; $display("FAIL async_pc: got %08h want %08h", pc_out, RESET_PC); end
        vectors++; if (instruction_out !== 32'd0) begin miscompares++; $display("FAIL async_instr: got %08h want 0", instruction_out); end
        vectors++; if (flush_out !== 1'b1) begin miscompares++; $display("FAIL async_flush: got %b want 1", flush_out); end
        vectors++; if (ifid_hold_out !== 1'b0) begin miscompares++; $display("FAIL async_hold: got %b want 0", ifid_hold_out); end
        sb.delete();
    endtask

    initial begin
        reset          = 1'b1;
        stall_in       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        #2;
        reset = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_slow_memory();
        test_redirect_discard();
        test_redirect_ack_stall();
        test_wrap_and_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch-side producer for the IF/ID pipeline register. Owns the program counter and issues word reads to instruction memory over a req/ack handshake. Buffers returned words in a 2-entry prefetch queue and presents the queue head to IF/ID as instruction, PC, flush and hold controls. Handles branch/jump redirects from later stages by discarding stale fetches.

Parameters:
RESET_PC, 32'h0040_0000, PC after reset and PC value presented with a bubble
QDEPTH, 2, prefetch queue entries (fixed at 2; count is 2 bits)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low
stall_in  input  1  hazard unit requests IF/ID hold
redirect_valid  input  1  one-cycle pulse: control transfer resolved
redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 00)
imem_req  output  1  fetch request, held until imem_ack
imem_addr  output  32  word address of request, stable while imem_req=1
imem_ack  input  1  read data valid this cycle; completes request
imem_rdata  input  32  instruction word, sampled when imem_ack=1
instruction_out  output  32  queue head instruction, 0 when queue empty
pc_out  output  32  queue head PC, RESET_PC when queue empty
flush_out  output  1  IF/ID loads bubble (instruction 0, PC RESET_PC)
ifid_hold_out  output  1  IF/ID holds contents (1 = no write)

Behaviour:
- Registered state: pc[31:0], queue (2 x {instr, pc}), count[1:0], head pointer, fsm state.
- Reset (reset=0, async): pc=RESET_PC, count=0, state=IDLE -> imem_req=0, imem_addr=RESET_PC, instruction_out=0, pc_out=RESET_PC, flush_out=1, ifid_hold_out=0.
- FSM states: IDLE (no request outstanding), FETCH (request outstanding, data wanted), DISCARD (request outstanding, data stale).
- imem_req = (state==FETCH || state==DISCARD); imem_addr = pc (registered, {pc[31:2],2'b00}).
- Combinational outputs: ifid_hold_out = stall_in & ~redirect_valid; flush_out = redirect_valid | (count==0); instruction_out/pc_out = head entry if count>0, else 0/RESET_PC.
- Consume: head popped at edge when count>0 & ~stall_in & ~redirect_valid.
- Push: in FETCH with imem_ack & ~redirect_valid -> enqueue {imem_rdata, pc}; pc <= pc+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0).
- count_next = count + push - pop; simultaneous push and pop on a 1-entry queue keeps count=1 and advances the head.
- IDLE -> FETCH when count<2; else stay.
- FETCH with ack: -> FETCH if count_next<2, else IDLE. Back-to-back zero-wait acks give 1 instruction/cycle.
- FETCH without ack: stay; imem_addr held.
- At most one request outstanding. A new request starts only when count<2, so queue overflow is impossible. An ack when not in FETCH/DISCARD is ignored.
- Redirect (redirect_valid=1) has priority over stall and push:
  - count<=0 and pc<={redirect_pc[31:2],00}.
  - flush_out=1 and ifid_hold_out=0 that cycle, so IF/ID takes a bubble.
  - IDLE -> FETCH.
  - FETCH or DISCARD with imem_ack -> data dropped, -> FETCH.
  - FETCH or DISCARD without imem_ack -> DISCARD. Old imem_addr is held until the ack, then pc is updated; the target is kept in pc_pending and loaded to pc on leaving DISCARD.
  - A second redirect in DISCARD overwrites pc_pending.
- DISCARD with ack: data dropped, pc<=pc_pending, -> FETCH.
- Stall with empty queue: hold=1 and flush=1 together; IF/ID holds, since hold dominates flush.
- Reset mid-request: imem_req drops asynchronously; memory must abandon the request.
- Latency: first imem_req in the 2nd cycle after reset release. With zero-wait memory, the first non-bubble instruction reaches IF/ID at the edge ending cycle 3.

Test Plan:
1. Reset release, zero-wait memory returning addr-derived words -> imem_addr 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; pc_out matches with flush_out=0 from cycle 3; one instruction per cycle.
2. stall_in=1 for 3 cycles while streaming -> ifid_hold_out=1; instruction_out/pc_out frozen; count saturates at 2 and imem_req drops to 0; on release, queued words emerge in order with no loss or duplication.
3. 3-cycle-latency memory -> imem_addr stable while waiting; flush_out=1 while queue empty; each word delivered with correct PC.
4. redirect_valid with redirect_pc=0x00400100 while a request to 0x00400010 is outstanding -> DISCARD; the 0x00400010 data is dropped on ack; next imem_addr=0x00400100; flush_out=1 in the redirect cycle; queue emptied.
5. Redirect coinciding with imem_ack and stall_in=1 -> ack data dropped, ifid_hold_out=0, flush_out=1; next request to target; redirect_pc=0x00400103 gives imem_addr 0x00400100.
6. pc redirected to 0xFFFFFFFC, then stream -> next imem_addr 0x00000000; plus async reset asserted mid-FETCH -> imem_req=0 immediately, outputs at reset values.
